// File: rtl/sliced_sub_pkg.sv
// Shared types and constants for the 4-bit-per-cycle sliced subtractor.
// Optional signed-overflow output is enabled by defining SUB_OVF_EN.
package sliced_sub_pkg;

    localparam int unsigned SLICE_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

    function automatic int unsigned nslice(input int unsigned width);
        return width / SLICE_W;
    endfunction

endpackage

// File: rtl/sub4_slice.sv
// Combinational 4-bit slice computing a + ~b + cin from a chain of full-adder cells.
module sub4_slice
    import sliced_sub_pkg::*;
(
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               cin,
    output logic [SLICE_W-1:0] s,
    output logic               cout
);

    logic [SLICE_W-1:0] nb;
    logic [SLICE_W:0]   c;

    assign nb   = ~b;
    assign c[0] = cin;

    for (genvar i = 0; i < SLICE_W; i++) begin : g_fa
        assign s[i]   = a[i] ^ nb[i] ^ c[i];
        assign c[i+1] = (a[i] & nb[i]) | (c[i] & (a[i] ^ nb[i]));
    end

    assign cout = c[SLICE_W];

endmodule

// File: rtl/sliced_subtractor.sv
// Multi-cycle a - b, one 4-bit slice per clock LSB first, with start/done handshake.
// Define SUB_OVF_EN to add the signed-overflow output ovf.
module sliced_subtractor
    import sliced_sub_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
`ifdef SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned NSLICE = nslice(WIDTH);
    localparam int unsigned CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam int unsigned SH_W   = CNT_W + 2;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NSLICE - 1);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0]   diff_q, diff_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               carry_q, carry_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               borrow_q, borrow_d;
`ifdef SUB_OVF_EN
    logic               ovf_q, ovf_d;
`endif

    logic [SH_W-1:0]    sh_amt;
    logic [SLICE_W-1:0] a_sl, b_sl, s;
    logic               cout;
    logic               accept;

    // Single slice adder fed from the operand slice selected by the counter
    assign sh_amt = {cnt_q, 2'b00};
    assign a_sl   = SLICE_W'(a_q >> sh_amt);
    assign b_sl   = SLICE_W'(b_q >> sh_amt);

    sub4_slice u_slice (
        .a    (a_sl),
        .b    (b_sl),
        .cin  (carry_q),
        .s    (s),
        .cout (cout)
    );

    assign accept = start && (state_q != RUN);

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        diff_d   = diff_q;
        cnt_d    = cnt_q;
        carry_d  = carry_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        borrow_d = borrow_q;
`ifdef SUB_OVF_EN
        ovf_d    = ovf_q;
`endif

        case (state_q)
            RUN: begin
                diff_d[sh_amt +: SLICE_W] = s;
                carry_d = cout;
                if (cnt_q == LAST) begin
                    borrow_d = ~cout;
`ifdef SUB_OVF_EN
                    ovf_d = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (s[SLICE_W-1] != a_q[WIDTH-1]);
`endif
                    state_d = DONE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // A start in IDLE or DONE launches a new operation and clears the old result
        if (accept) begin
            state_d  = RUN;
            a_d      = a;
            b_d      = b;
            cnt_d    = '0;
            carry_d  = 1'b1;
            busy_d   = 1'b1;
            diff_d   = '0;
            borrow_d = 1'b0;
`ifdef SUB_OVF_EN
            ovf_d    = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            diff_q   <= '0;
            cnt_q    <= '0;
            carry_q  <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            borrow_q <= 1'b0;
`ifdef SUB_OVF_EN
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            diff_q   <= diff_d;
            cnt_q    <= cnt_d;
            carry_q  <= carry_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            borrow_q <= borrow_d;
`ifdef SUB_OVF_EN
            ovf_q    <= ovf_d;
`endif
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign diff       = diff_q;
    assign borrow_out = borrow_q;
`ifdef SUB_OVF_EN
    assign ovf        = ovf_q;
`endif

endmodule

// File: tb/tb_sliced_subtractor.sv
// Directed self-checking bench for sliced_subtractor at WIDTH=16; ovf checks under SUB_OVF_EN.
module tb_sliced_subtractor;

    localparam int unsigned W  = 16;
    localparam int unsigned NS = 4;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         borrow_out;
`ifdef SUB_OVF_EN
    logic         ovf;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    sliced_subtractor #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .done       (done),
        .diff       (diff),
        .borrow_out (borrow_out)
`ifdef SUB_OVF_EN
        ,
        .ovf        (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full operation: start for one cycle, scramble inputs, check timing and result
    task automatic run_op(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic [W-1:0] exp_diff, input logic exp_borrow, input logic exp_ovf);
        a = av; b = bv; start = 1'b1;
        step();
        start = 1'b0; a = ~av; b = 16'h5A5A;
        check({tag, "_busy_start"}, busy, 1'b1);
        check({tag, "_diff_clr"}, diff, 16'h0000);
        check({tag, "_borrow_clr"}, borrow_out, 1'b0);
        for (int i = 1; i <= NS; i++) begin
            step();
            if (i < NS) begin
                check({tag, "_busy_run"}, busy, 1'b1);
                check({tag, "_done_early"}, done, 1'b0);
            end
        end
        check({tag, "_done"}, done, 1'b1);
        check({tag, "_busy_done"}, busy, 1'b0);
        check({tag, "_diff"}, diff, exp_diff);
        check({tag, "_borrow"}, borrow_out, exp_borrow);
`ifdef SUB_OVF_EN
        check({tag, "_ovf"}, ovf, exp_ovf);
`endif
        step();
        check({tag, "_done_pulse"}, done, 1'b0);
        check({tag, "_diff_hold"}, diff, exp_diff);
        check({tag, "_borrow_hold"}, borrow_out, exp_borrow);
        check({tag, "_idle"}, busy, 1'b0);
    endtask

    initial begin
        int pulses;
        int c;
        logic [W-1:0] diff_at_done;
        logic [W-1:0] op_a [3];
        logic [W-1:0] op_b [3];
        logic [W-1:0] op_d [3];
        logic         op_br [3];

        rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
        step();
        step();
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_diff", diff, 16'h0000);
        check("rst_borrow", borrow_out, 1'b0);
`ifdef SUB_OVF_EN
        check("rst_ovf", ovf, 1'b0);
`endif
        rst_n = 1'b1;
        step();

        run_op("t1", 16'h1234, 16'h0234, 16'h1000, 1'b0, 1'b0);
        run_op("t2", 16'h0000, 16'h0001, 16'hFFFF, 1'b1, 1'b0);
        run_op("t3a", 16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b1);
        run_op("t3b", 16'h7FFF, 16'hFFFF, 16'h8000, 1'b1, 1'b1);

        // Start during RUN must be ignored and not queued
        a = 16'h0005; b = 16'h0003; start = 1'b1;
        step();
        start = 1'b0;
        step();
        start = 1'b1; a = 16'hFFFF; b = 16'hFFFF;
        step();
        start = 1'b0;
        pulses = 0;
        diff_at_done = '0;
        for (int i = 0; i < 7; i++) begin
            step();
            if (done === 1'b1) begin
                pulses++;
                diff_at_done = diff;
            end
        end
        check("t4_pulses", pulses, 1);
        check("t4_diff", diff_at_done, 16'h0002);
        check("t4_idle", busy, 1'b0);

        // Reset in the middle of RUN
        a = 16'hAAAA; b = 16'h1111; start = 1'b1;
        step();
        start = 1'b0;
        step();
        check("t5_partial", diff, 16'h0009);
        rst_n = 1'b0;
        #1;
        check("t5_busy", busy, 1'b0);
        check("t5_done", done, 1'b0);
        check("t5_diff", diff, 16'h0000);
        check("t5_borrow", borrow_out, 1'b0);
        step();
        check("t5_done_hold", done, 1'b0);
        step();
        check("t5_done_hold2", done, 1'b0);
        rst_n = 1'b1;
        step();
        check("t5_no_resume", busy, 1'b0);
        run_op("t5_next", 16'h00FF, 16'h000F, 16'h00F0, 1'b0, 1'b0);

        // Back-to-back with start held high; operands updated at each done
        op_a[0] = 16'h1000; op_b[0] = 16'h0001; op_d[0] = 16'h0FFF; op_br[0] = 1'b0;
        op_a[1] = 16'h0003; op_b[1] = 16'h0005; op_d[1] = 16'hFFFE; op_br[1] = 1'b1;
        op_a[2] = 16'hABCD; op_b[2] = 16'h1234; op_d[2] = 16'h9999; op_br[2] = 1'b0;
        a = op_a[0]; b = op_b[0]; start = 1'b1;
        for (int k = 0; k < 3; k++) begin
            c = 0;
            do begin
                step();
                c++;
            end while (done !== 1'b1 && c < 8);
            check("t6_done", done, 1'b1);
            check("t6_diff", diff, op_d[k]);
            check("t6_borrow", borrow_out, op_br[k]);
            if (k < 2) begin
                a = op_a[k+1]; b = op_b[k+1];
                step();
                check("t6_rearm", busy, 1'b1);
            end else begin
                start = 1'b0;
                step();
                check("t6_stop", busy, 1'b0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
